// File: rtl/usb_rx_rcu_if.sv
// Strobes from the RX bit timer/line detectors into the receive control unit,
// and the control outputs back to the timer and RX FIFO.
interface usb_rx_rcu_if;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       receiving;
    logic       w_enable;
    logic       r_error;
    logic       packet_done;

    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data,
        input  receiving, w_enable, r_error, packet_done
    );

    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data,
        output receiving, w_enable, r_error, packet_done
    );
endinterface

// File: rtl/usb_rx_rcu.sv
// USB receive control unit: frames packets, checks SYNC, qualifies FIFO
// writes and flags framing errors. Outputs are registered off next state.
module usb_rx_rcu #(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64
) (
    input logic         clk,
    input logic         n_rst,
    usb_rx_rcu_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, START, CHK_SYNC, RCV, STORE, EOP_DONE, ERR_WAIT, EIDLE
    } state_t;

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    state_t     state, nxt;
    logic [2:0] bit_cnt;
    logic [6:0] byte_cnt;
    logic       eop_bit;

    assign eop_bit = bus.eop & bus.shift_enable;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (bus.d_edge) nxt = START;
            START: begin
                if (bus.byte_received) nxt = CHK_SYNC;
                else if (eop_bit)      nxt = ERR_WAIT;
            end
            CHK_SYNC: nxt = (bus.rcv_data == SYNC_BYTE) ? RCV : ERR_WAIT;
            RCV: begin
                // a completed byte wins over a coincident EOP sample
                if (bus.byte_received)
                    nxt = (byte_cnt == MAX_CNT) ? ERR_WAIT : STORE;
                else if (eop_bit)
                    nxt = (bit_cnt == 3'd0) ? EOP_DONE : ERR_WAIT;
            end
            STORE:    nxt = RCV;
            EOP_DONE: if (bus.d_edge) nxt = IDLE;
            ERR_WAIT: if (eop_bit) nxt = EIDLE;
            EIDLE:    if (bus.d_edge) nxt = START;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            bus.receiving   <= 1'b0;
            bus.w_enable    <= 1'b0;
            bus.r_error     <= 1'b0;
            bus.packet_done <= 1'b0;
        end else begin
            state           <= nxt;
            bus.receiving   <= !(nxt inside {IDLE, EIDLE});
            bus.w_enable    <= (nxt == STORE);
            bus.r_error     <= (nxt inside {ERR_WAIT, EIDLE});
            bus.packet_done <= (nxt == EOP_DONE) && (state != EOP_DONE);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= 3'd0;
        end else if (state inside {IDLE, EIDLE}) begin
            bit_cnt <= 3'd0;
        end else if (bus.byte_received) begin
            bit_cnt <= 3'd0;
        end else if (bus.shift_enable) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt <= 7'd0;
        end else if (nxt == START && state != START) begin
            byte_cnt <= 7'd0;
        end else if (nxt == STORE) begin
            byte_cnt <= byte_cnt + 7'd1;
        end
    end
endmodule

// File: tb/tb_usb_rx_rcu.sv
// Scoreboard bench for usb_rx_rcu: stimulus pushes expected writes, done
// pulses and error rises; a negedge monitor pops and compares them.
module tb_usb_rx_rcu;
    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_DONE = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic n_rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];

    usb_rx_rcu_if dif();

    usb_rx_rcu #(.SYNC_BYTE(8'h80), .MAX_BYTES(4)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [1:0] k, logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic check_out(string nm, logic [3:0] exp);
        logic [3:0] act;
        act = {dif.receiving, dif.w_enable, dif.r_error, dif.packet_done};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {rcv,we,err,done} got %b want %b", nm, act, exp);
        end
    endtask

    task automatic pulse_edge();
        dif.d_edge = 1'b1;
        tick();
        dif.d_edge = 1'b0;
    endtask

    task automatic shift_bits(int n);
        for (int i = 0; i < n; i++) begin
            dif.shift_enable = 1'b1;
            tick();
            dif.shift_enable = 1'b0;
            tick();
        end
    endtask

    task automatic send_byte(logic [7:0] b, logic with_eop);
        shift_bits(8);
        dif.rcv_data      = b;
        dif.byte_received = 1'b1;
        dif.eop           = with_eop;
        dif.shift_enable  = with_eop;
        tick();
        dif.byte_received = 1'b0;
        dif.eop           = 1'b0;
        dif.shift_enable  = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_eop();
        dif.eop          = 1'b1;
        dif.shift_enable = 1'b1;
        tick();
        dif.eop          = 1'b0;
        dif.shift_enable = 1'b0;
        tick();
    endtask

    // monitor: every output event must match the head of the queue
    logic prev_br = 1'b0;
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (dif.w_enable) begin
            n_cmp++;
            if (!prev_br) begin
                n_bad++;
                $display("FAIL we_latency: w_enable got 1 without byte_received the cycle before");
            end
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL write: got unexpected write of %h, want none", dif.rcv_data);
            end else begin
                e = q.pop_front();
                if (e.kind != K_WR || e.data != dif.rcv_data) begin
                    n_bad++;
                    $display("FAIL write: got write %h, want kind %0d data %h",
                             dif.rcv_data, e.kind, e.data);
                end
            end
        end
        if (dif.packet_done) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL done: got unexpected packet_done, want none");
            end else begin
                e = q.pop_front();
                if (e.kind != K_DONE) begin
                    n_bad++;
                    $display("FAIL done: got packet_done, want kind %0d", e.kind);
                end
            end
        end
        if (dif.r_error && !prev_err) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL error: got unexpected r_error rise, want none");
            end else begin
                e = q.pop_front();
                if (e.kind != K_ERR) begin
                    n_bad++;
                    $display("FAIL error: got r_error rise, want kind %0d", e.kind);
                end
            end
        end
        prev_br  = dif.byte_received;
        prev_err = dif.r_error;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        n_rst             = 1'b0;
        dif.d_edge        = 1'b0;
        dif.eop           = 1'b0;
        dif.shift_enable  = 1'b0;
        dif.byte_received = 1'b0;
        dif.rcv_data      = 8'h00;
        tick();
        tick();
        check_out("reset", 4'b0000);
        n_rst = 1'b1;
        tick();
        check_out("idle", 4'b0000);

        // clean packet: SYNC, C3, A5, EOP
        pulse_edge();
        check_out("rcv_rise", 4'b1000);
        send_byte(8'h80, 1'b0);
        check_out("after_sync", 4'b1000);
        push(K_WR, 8'hC3);
        send_byte(8'hC3, 1'b0);
        push(K_WR, 8'hA5);
        send_byte(8'hA5, 1'b0);
        check_out("mid_pkt", 4'b1000);
        push(K_DONE, 8'h00);
        send_eop();
        check_out("eop_done", 4'b1000);
        pulse_edge();
        check_out("back_idle", 4'b0000);

        // bad SYNC
        tick();
        pulse_edge();
        push(K_ERR, 8'h00);
        send_byte(8'h81, 1'b0);
        check_out("bad_sync", 4'b1010);
        send_eop();
        check_out("eidle", 4'b0010);
        pulse_edge();
        check_out("err_clear", 4'b1000);

        // zero-data packet in the restarted frame
        send_byte(8'h80, 1'b0);
        push(K_DONE, 8'h00);
        send_eop();
        check_out("zero_data", 4'b1000);
        pulse_edge();
        check_out("zero_idle", 4'b0000);

        // partial byte at EOP
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_WR, 8'h3C);
        send_byte(8'h3C, 1'b0);
        shift_bits(3);
        push(K_ERR, 8'h00);
        send_eop();
        check_out("partial", 4'b1010);
        send_eop();
        check_out("partial_eidle", 4'b0010);

        // overflow: 4 stores allowed, 5th byte is an error
        pulse_edge();
        check_out("ovf_start", 4'b1000);
        send_byte(8'h80, 1'b0);
        push(K_WR, 8'h11);
        send_byte(8'h11, 1'b0);
        push(K_WR, 8'h22);
        send_byte(8'h22, 1'b0);
        push(K_WR, 8'h33);
        send_byte(8'h33, 1'b0);
        push(K_WR, 8'h44);
        send_byte(8'h44, 1'b0);
        check_out("ovf_4th", 4'b1000);
        push(K_ERR, 8'h00);
        send_byte(8'h55, 1'b0);
        check_out("ovf_err", 4'b1010);
        send_eop();
        check_out("ovf_eidle", 4'b0010);

        // byte_received coincident with EOP sample
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_WR, 8'h5A);
        send_byte(8'h5A, 1'b1);
        check_out("coinc_rcv", 4'b1000);
        push(K_DONE, 8'h00);
        send_eop();
        check_out("coinc_done", 4'b1000);
        pulse_edge();
        check_out("coinc_idle", 4'b0000);

        // async reset mid-packet after two stored bytes
        pulse_edge();
        send_byte(8'h80, 1'b0);
        push(K_WR, 8'hC3);
        send_byte(8'hC3, 1'b0);
        push(K_WR, 8'hA5);
        send_byte(8'hA5, 1'b0);
        shift_bits(2);
        check_out("pre_reset", 4'b1000);
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check_out("async_reset", 4'b0000);
        tick();
        n_rst = 1'b1;
        tick();
        send_byte(8'h77, 1'b0);
        check_out("no_edge_byte", 4'b0000);
        tick();
        tick();

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending events, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
